// File: rtl/tt_sub_pkg.sv
// Shared constants, pin map and FSM state type for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_sub_pkg;

    // Operand width is fixed by the tile pin budget
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    // Counter value of the last (MSB) bit of an operation
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Pin indices: start on uio_in, status bits on uo_out
    localparam int START_BIT  = 0;
    localparam int BORROW_BIT = 4;
    localparam int BUSY_BIT   = 5;
    localparam int DONE_BIT   = 6;
    localparam int OVF_BIT    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor: d = a - b, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/tt_um_serial_subtractor_christ.sv
// Bit-serial 4-bit subtractor, LSB first, one difference bit per clock. Optional macro: SIGNED_OVF_EN.
// Latency: WIDTH cycles from the capturing start edge; one result per WIDTH+1 cycles back to back.
// Backpressure: none; start is ignored while busy, results hold until the next start.
module tt_um_serial_subtractor_christ
    import tt_sub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res_sr;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               r_bout;
    logic               w_start;
    logic               w_load;
    logic               w_last;
    logic               w_d1;
    logic               w_bo1;
    logic               w_d;
    logic               w_bo2;
    logic               w_bout;
    logic               w_unused;
`ifdef SIGNED_OVF_EN
    logic               r_ovf;
`endif

    assign w_start  = uio_in[START_BIT];
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_unused = &{1'b0, ena, uio_in[7:1]};

    // Full subtractor stage: first half subtracts b from a, second subtracts the incoming borrow
    half_subtractor u_hs_ab (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .d  (w_d1),
        .bo (w_bo1)
    );

    half_subtractor u_hs_bin (
        .a  (w_d1),
        .b  (r_borrow),
        .d  (w_d),
        .bo (w_bo2)
    );

    assign w_bout = w_bo1 | w_bo2;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured outside SHIFT
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_start) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res_sr <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
`ifdef SIGNED_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_load) begin
            r_a      <= ui_in[WIDTH-1:0];
            r_b      <= ui_in[2*WIDTH-1:WIDTH];
            r_cnt    <= '0;
            r_borrow <= 1'b0;
`ifdef SIGNED_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (r_state == SHIFT) begin
            r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= {w_d, r_res_sr[WIDTH-1:1]};
                r_bout   <= w_bout;
`ifdef SIGNED_OVF_EN
                // On the last bit r_a[0]/r_b[0] are the captured operand MSBs
                r_ovf    <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
`endif
            end
        end
    end

    // Output pin assembly; result bits only change at completion
    always_comb begin
        uo_out             = '0;
        uo_out[WIDTH-1:0]  = r_result;
        uo_out[BORROW_BIT] = r_bout;
        uo_out[BUSY_BIT]   = (r_state == SHIFT);
        uo_out[DONE_BIT]   = (r_state == DONE);
`ifdef SIGNED_OVF_EN
        uo_out[OVF_BIT]    = r_ovf;
`endif
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_serial_subtractor_christ.sv
// Self-checking bench for the bit-serial subtractor tile.
// Stimulus pushes expected results; a monitor pops on each rising done.
// Reset and idle behaviour are checked directly by the stimulus process.
module tb_tt_um_serial_subtractor_christ;

    typedef struct packed {
        logic [3:0] d;
        logic       b;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   busy_run;
    logic prev_done;

    tt_um_serial_subtractor_christ dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected overflow flag only exists when the feature is built
    function automatic exp_t mk(input logic [3:0] d, input logic b, input logic v);
        exp_t e;
        e.d = d;
        e.b = b;
`ifdef SIGNED_OVF_EN
        e.v = v;
`else
        e.v = 1'b0 & v;
`endif
        return e;
    endfunction

    // Bounded wait on negedges until done is high
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (uo_out[6] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (uo_out[6] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=done0 required=done1", name);
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input exp_t e);
        @(negedge clk);
        ui_in     = {b, a};
        uio_in[0] = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        uio_in[0] = 1'b0;
        ui_in     = 8'hFF;
        wait_done("op_wait");
        @(negedge clk);
    endtask

    // Monitor: on each rising done, compare against the oldest expectation
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (uo_out[5] === 1'b1) busy_run++;
            if (uo_out[6] === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h required=none", uo_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("diff_borrow", {3'b0, uo_out[4:0]}, {3'b0, e.b, e.d});
                    chk("ovf", {7'b0, uo_out[7]}, {7'b0, e.v});
                    chk("busy_cycles", 8'(busy_run), 8'd4);
                    chk("uio_zero", uio_out | uio_oe, 8'h00);
                end
                busy_run = 0;
            end
            prev_done = uo_out[6];
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        busy_run  = 0;
        prev_done = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        uio_in    = 8'h00;
        rst_n     = 1'b0;
        #1;
        chk("reset_uo", uo_out, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_uo", uo_out, 8'h00);
        chk("idle_uio_out", uio_out, 8'h00);
        chk("idle_uio_oe", uio_oe, 8'h00);

        // Basic subtractions
        run_op(4'd9, 4'd6, mk(4'h3, 1'b0, 1'b1));
        run_op(4'd3, 4'd5, mk(4'hE, 1'b1, 1'b0));
        run_op(4'd7, 4'd7, mk(4'h0, 1'b0, 1'b0));

        // Start held: second op launches straight from DONE; operand changes in SHIFT ignored
        @(negedge clk);
        ui_in     = {4'd4, 4'd12};
        uio_in[0] = 1'b1;
        sb.push_back(mk(4'h8, 1'b0, 1'b0));
        sb.push_back(mk(4'hF, 1'b1, 1'b0));
        @(negedge clk);
        ui_in = {4'd3, 4'd2};
        wait_done("held_first");
        @(negedge clk);
        chk("held_restart_busy", {7'b0, uo_out[5]}, 8'd1);
        ui_in     = {4'd0, 4'd15};
        uio_in[0] = 1'b0;
        wait_done("held_second");
        @(negedge clk);

        // Reset during the second SHIFT cycle
        ui_in     = {4'd6, 4'd9};
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_uo", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", uo_out, 8'h00);
        run_op(4'd1, 4'd1, mk(4'h0, 1'b0, 1'b0));

        // Signed overflow cases
        run_op(4'd8, 4'd1, mk(4'h7, 1'b0, 1'b1));
        run_op(4'd5, 4'd2, mk(4'h3, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_serial_subtractor_christ.md
# tt_um_serial_subtractor_christ

Bit-serial 4-bit subtractor for the Tiny Tapeout tile. It is the inverse-direction companion of the team's combinational half-adder tile. Two operands are captured on a start request, then one difference bit per clock is computed LSB-first through a half-subtractor pair. The block then presents the difference, the final borrow and a done flag on the dedicated outputs. It is the top-level user module of its tile.

## Interface
Parameters:
- WIDTH, 4: operand width in bits. Fixed by the pin budget; do not override at top level.
- CNT_W, 2: bit-counter width, equal to clog2(WIDTH).

Ports:
- clk, input, 1: system clock; all state on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: tile powered; ignored.
- ui_in, input, 8: [3:0] operand A (minuend), [7:4] operand B (subtrahend).
- uio_in, input, 8: [0] start (level, sampled on clk); [7:1] unused.
- uo_out, output, 8: [3:0] difference; [4] borrow-out; [5] busy; [6] done; [7] signed overflow when SIGNED_OVF_EN is defined, else 0.
- uio_out, output, 8: constant 0.
- uio_oe, output, 8: constant 0 (all uio pins are inputs).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state: IDLE.
- IDLE, start=1: latch A and B into shift registers; clear the borrow flop and the bit counter; go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle, for bit i (LSB-first):
  - d = a_i ^ b_i ^ bin.
  - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
  - d shifts into the MSB of the result shift register; A and B shift right; borrow <= bout; counter increments.
- SHIFT, counter = WIDTH-1: after that bit's update, copy the result shift register into the output result register and the final borrow into the output borrow register; go to DONE.
- DONE: done=1; result and borrow held.
  - start=1 in DONE: start a new operation exactly as from IDLE, going directly to SHIFT.
  - start=0 in DONE: stay in DONE.
- start while in SHIFT: ignored; the operation is not restarted or extended.
- Arithmetic: the result is (A - B) mod 2^WIDTH; borrow=1 iff A < B (unsigned).
- Output visibility:
  - uo_out[3:0] and uo_out[4] show only the last completed operation and do not change during SHIFT.
  - busy=1 iff state=SHIFT.
  - done=1 iff state=DONE.
- Reset asserted mid-operation: state returns to IDLE immediately and asynchronously; all registers clear; no partial result is exposed.

## Timing
- Reset values:
  - uo_out = 8'h00: difference 0, borrow 0, busy 0, done 0, overflow 0.
  - uio_out = 0 and uio_oe = 0 at all times.
- Edge E0: start is sampled high in IDLE or DONE. busy=1 from E0.
- Edges E1..E4: bits 0..3 are computed, one per edge. At E4, the result, borrow and overflow update, busy falls and done rises.
- Latency: WIDTH cycles from the capturing edge to a valid result. Back-to-back throughput is one result per WIDTH+1 cycles.
- The operands must be stable only at E0; later changes on ui_in have no effect.

## Configuration
- SIGNED_OVF_EN defined: an overflow register is loaded at completion with (a_msb ^ b_msb) & (a_msb ^ d_msb), using the captured operand MSBs and the result MSB. It drives uo_out[7] and clears on reset and at each new start.
- SIGNED_OVF_EN not defined: no overflow logic is built and uo_out[7] is tied to 0.

## Structure
- Shared package tt_sub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - constants WIDTH=4 and CNT_W=2;
  - the pin-index constants for the start, borrow, busy, done and overflow bits.
- One sub-module, half_subtractor (inputs a, b; outputs d, bo), instantiated twice to form the full subtractor stage.
- All remaining logic lives in the top module.

## Test plan
- Reset, then idle 3 cycles: uo_out=8'h00, uio_out=0, uio_oe=0.
- A=9, B=6, start pulsed for 1 cycle: busy=1 for 4 cycles, then done=1, difference=3, borrow=0.
- A=3, B=5: difference=4'hE, borrow=1. A=B=7: difference=0, borrow=0.
- Start held high through an operation with A=12, B=4: the first result is 8. A second operation begins directly from DONE. Operand changes during SHIFT are ignored.
- rst_n pulsed low during the 2nd SHIFT cycle: outputs go to 0 immediately, the FSM restarts from IDLE, and the next A=1, B=1 gives 0.
- With SIGNED_OVF_EN: A=8, B=1 gives difference=7, ovf=1; A=5, B=2 gives ovf=0. Without the macro, uo_out[7] stays 0 for both.
